// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Request/result bundle between EX-stage control and the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MDOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             WEHI;
  logic             WELO;
  logic [WIDTH-1:0] HiRe;
  logic [WIDTH-1:0] LoRe;

  modport master (
    output Start, MDOp, A, B,
    input  Busy, Done, WEHI, WELO, HiRe, LoRe
  );

  modport slave (
    input  Start, MDOp, A, B,
    output Busy, Done, WEHI, WELO, HiRe, LoRe
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
//                One shift-add / restoring shift-subtract step per clock on
//                operand magnitudes, sign fix-up on the last step.
//                Optional macro MULDIV_FAST_MUL_EN: multiplies complete in a
//                single edge through a combinational multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input wire            Clk,
  input wire            Reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_is_div, w_is_div_nxt;
  logic               r_neg_res, w_neg_res_nxt;   // product / quotient negative
  logic               r_neg_rem, w_neg_rem_nxt;   // remainder negative
  logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_acc_hi, w_acc_hi_nxt;     // product high half or partial remainder
  logic [WIDTH-1:0]   r_acc_lo, w_acc_lo_nxt;     // multiplier/product low or dividend/quotient
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [WIDTH-1:0]   r_hi_re, w_hi_re_nxt;
  logic [WIDTH-1:0]   r_lo_re, w_lo_re_nxt;

  // Operand magnitudes and sign flags at request time
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_accept;

  assign w_a_neg  = ~bus.MDOp[0] & bus.A[WIDTH-1];
  assign w_b_neg  = ~bus.MDOp[0] & bus.B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag  = w_b_neg ? -bus.B : bus.B;
  // A request is only taken when no operation is iterating
  assign w_accept = bus.Start && (r_state != CALC);

  // Multiply step: conditional add into the high half, then shift the pair right
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Divide step: shift next dividend bit into the remainder, subtract if it fits.
  // When it fits the true difference is below the divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;
  assign w_rem_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_fits     = (w_rem_sh >= {1'b0, r_opnd});
  assign w_div_hi   = w_fits ? w_rem_diff : w_rem_sh[WIDTH-1:0];
  assign w_div_lo   = {r_acc_lo[WIDTH-2:0], w_fits};

  logic [WIDTH-1:0]   w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  assign w_step_hi  = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo  = r_is_div ? w_div_lo : w_mul_lo;
  assign w_prod_neg = -{w_step_hi, w_step_lo};
  // Product negated as a whole; quotient truncates toward zero, remainder follows dividend
  assign w_fix_hi = r_is_div ? (r_neg_rem ? -w_step_hi : w_step_hi)
                             : (r_neg_res ? w_prod_neg[2*WIDTH-1:WIDTH] : w_step_hi);
  assign w_fix_lo = r_is_div ? (r_neg_res ? -w_step_lo : w_step_lo)
                             : (r_neg_res ? w_prod_neg[WIDTH-1:0] : w_step_lo);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extend to 2*WIDTH so one unsigned multiply serves both MULT and MULTU
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{w_a_neg}}, bus.A} * {{WIDTH{w_b_neg}}, bus.B};
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_is_div_nxt  = r_is_div;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_opnd_nxt    = r_opnd;
    w_acc_hi_nxt  = r_acc_hi;
    w_acc_lo_nxt  = r_acc_lo;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_hi_re_nxt   = r_hi_re;
    w_lo_re_nxt   = r_lo_re;

    case (r_state)
      CALC: begin
        w_acc_hi_nxt = w_step_hi;
        w_acc_lo_nxt = w_step_lo;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == c_last) begin
          w_state_nxt = FIN;
          w_done_nxt  = 1'b1;
          w_hi_re_nxt = w_fix_hi;
          w_lo_re_nxt = w_fix_lo;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_accept) begin
      w_state_nxt   = CALC;
      w_busy_nxt    = 1'b1;
      w_cnt_nxt     = '0;
      w_is_div_nxt  = bus.MDOp[1];
      w_neg_res_nxt = w_a_neg ^ w_b_neg;
      w_neg_rem_nxt = w_a_neg;
      w_acc_hi_nxt  = '0;
      w_acc_lo_nxt  = bus.MDOp[1] ? w_a_mag : w_b_mag;
      w_opnd_nxt    = bus.MDOp[1] ? w_b_mag : w_a_mag;
`ifdef MULDIV_FAST_MUL_EN
      if (!bus.MDOp[1]) begin
        w_state_nxt = FIN;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_hi_re_nxt = w_fast_prod[2*WIDTH-1:WIDTH];
        w_lo_re_nxt = w_fast_prod[WIDTH-1:0];
      end
`endif
    end
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi_re   <= '0;
      r_lo_re   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_is_div  <= w_is_div_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_opnd    <= w_opnd_nxt;
      r_acc_hi  <= w_acc_hi_nxt;
      r_acc_lo  <= w_acc_lo_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_hi_re   <= w_hi_re_nxt;
      r_lo_re   <= w_lo_re_nxt;
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.WEHI = r_done;
  assign bus.WELO = r_done;
  assign bus.HiRe = r_hi_re;
  assign bus.LoRe = r_lo_re;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit c_fast = 1'b1;
`else
  localparam bit c_fast = 1'b0;
`endif

  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fails;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) u_dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Edges after the accepting edge until Done shows up
  function automatic int exp_lat(input logic [1:0] op);
    return (c_fast && !op[1]) ? 0 : 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.Done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(op, a, b);
    check_eq({tag, "_busy"}, 64'(bus.Busy), (c_fast && !op[1]) ? 64'd0 : 64'd1);
    wait_done(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat(op)));
    check_eq({tag, "_hi"}, 64'(bus.HiRe), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(bus.LoRe), 64'(exp_lo));
    check_eq({tag, "_we"}, 64'({bus.WEHI, bus.WELO, bus.Busy}), 64'b110);
    tick();
    check_eq({tag, "_done_drop"}, 64'({bus.Done, bus.WEHI, bus.WELO}), 64'd0);
    check_eq({tag, "_hold"}, {bus.HiRe, bus.LoRe}, {exp_hi, exp_lo});
  endtask

  initial begin
    int lat;
    int done_seen;
    n_asserts = 0;
    n_fails   = 0;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 2'b00;
    bus.A     = '0;
    bus.B     = '0;

    repeat (2) tick();
    check_eq("rst_busy", 64'(bus.Busy), 64'd0);
    check_eq("rst_done", 64'({bus.Done, bus.WEHI, bus.WELO}), 64'd0);
    check_eq("rst_res", {bus.HiRe, bus.LoRe}, 64'd0);

    // Start together with Reset: reset wins
    bus.Start = 1'b1;
    bus.MDOp  = c_divu;
    tick();
    check_eq("rst_start_busy", 64'({bus.Busy, bus.Done}), 64'd0);
    bus.Start = 1'b0;
    rst       = 1'b0;
    tick();

    do_op("mult_neg",   c_mult,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("multu_max",  c_multu, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE);
    do_op("mult_minsq", c_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("div_neg",    c_div,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_negb",   c_div,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op("divu",       c_divu,  32'd100,      32'd7,         32'd2,         32'd14);
    do_op("divu_zero",  c_divu,  32'd5,        32'd0,         32'd5,         32'hFFFF_FFFF);
    do_op("div_zero_n", c_div,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'd1);
    do_op("div_ovf",    c_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);

    // Start while busy is ignored; operands latched at T0 are kept
    issue(c_divu, 32'd100, 32'd7);
    repeat (9) tick();
    issue(c_multu, 32'd3, 32'd3);
    wait_done(lat);
    check_eq("ign_lat", 64'(lat + 10), 64'd32);
    check_eq("ign_res", {bus.HiRe, bus.LoRe}, {32'd2, 32'd14});

    // Back-to-back request taken in FIN
    issue(c_div, 32'hFFFF_FFF9, 32'd2);
    check_eq("b2b_busy", 64'({bus.Busy, bus.Done}), 64'b10);
    wait_done(lat);
    check_eq("b2b_lat", 64'(lat), 64'd32);
    check_eq("b2b_res", {bus.HiRe, bus.LoRe}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();

    // Reset in the middle of a long operation
    issue(c_divu, 32'd1000, 32'd3);
    repeat (14) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 64'({bus.Busy, bus.Done, bus.WEHI, bus.WELO}), 64'd0);
    check_eq("abort_res", {bus.HiRe, bus.LoRe}, 64'd0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done || bus.WEHI || bus.WELO || bus.Busy) done_seen++;
    end
    check_eq("abort_quiet", 64'(done_seen), 64'd0);

    do_op("multu_after", c_multu, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Global watchdog keeps the run bounded
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
